// File: rtl/inst_fetch_unit.sv
// Instruction fetch unit: owns the PC, reads a combinational instruction memory and
// buffers {pc, instr} pairs in a small prefetch FIFO that feeds decode.
module inst_fetch_unit #(
   parameter int               FIFO_DEPTH = 4,
   parameter int               ADDR_W     = 8,
   parameter int               DATA_W     = 32,
   parameter logic [ADDR_W-1:0] RESET_PC  = '0
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          fetch_en,
   output logic [ADDR_W-1:0]             imem_addr,
   input  logic [DATA_W-1:0]             imem_instr,
   input  logic                          redirect_valid,
   input  logic [ADDR_W-1:0]             redirect_pc,
   output logic                          if_valid,
   input  logic                          if_ready,
   output logic [DATA_W-1:0]             if_instr,
   output logic [ADDR_W-1:0]             if_pc,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

   logic [ADDR_W-1:0] pc;
   logic [DATA_W-1:0] instr_mem [FIFO_DEPTH];
   logic [ADDR_W-1:0] pc_mem    [FIFO_DEPTH];
   logic [PTR_W-1:0]  rd_ptr;
   logic [PTR_W-1:0]  wr_ptr;
   logic [CNT_W-1:0]  count;
   logic              push;
   logic              pop;

   // Handshake: the head entry transfers on any edge where if_valid and if_ready are both 1;
   // if_valid never depends on if_ready, and the head stays stable until it is taken.
   assign pop  = if_valid & if_ready;
   assign push = fetch_en & ~redirect_valid & ((count < DEPTH_C) | pop);

   assign imem_addr  = pc;
   assign fifo_count = count;
   assign if_valid   = (count != '0);
   assign if_instr   = if_valid ? instr_mem[rd_ptr] : '0;
   assign if_pc      = if_valid ? pc_mem[rd_ptr]    : '0;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pc     <= RESET_PC;
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (redirect_valid) begin
         // Flush wins over any push/pop this cycle; the target is word-aligned silently.
         pc     <= redirect_pc & ~ADDR_W'(3);
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
            pc     <= pc + ADDR_W'(4);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         case ({push, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   // Storage needs no reset: entries are only visible through a valid pointer window.
   always_ff @(posedge clk) begin
      if (push) begin
         instr_mem[wr_ptr] <= imem_instr;
         pc_mem[wr_ptr]    <= pc;
      end
   end

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Bench for inst_fetch_unit: directed vector table, hand sequences and random traffic,
// all checked against a queue-based model of the fetch buffer.
module tb_inst_fetch_unit;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        fetch_en = 1'b0;
   logic [7:0]  imem_addr;
   logic [31:0] imem_instr;
   logic        redirect_valid = 1'b0;
   logic [7:0]  redirect_pc = 8'h00;
   logic        if_valid;
   logic        if_ready = 1'b0;
   logic [31:0] if_instr;
   logic [7:0]  if_pc;
   logic [2:0]  fifo_count;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   inst_fetch_unit #(.FIFO_DEPTH(4), .ADDR_W(8), .DATA_W(32), .RESET_PC(8'h00)) dut (
      .clk(clk), .rst_n(rst_n), .fetch_en(fetch_en), .imem_addr(imem_addr),
      .imem_instr(imem_instr), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .if_valid(if_valid), .if_ready(if_ready), .if_instr(if_instr), .if_pc(if_pc),
      .fifo_count(fifo_count)
   );

   // Combinational instruction memory: the program image plus a filler pattern elsewhere.
   function automatic logic [31:0] mem_word(input logic [7:0] a);
      case (a)
         8'h00:   mem_word = 32'h00007033;
         8'h04:   mem_word = 32'h00100093;
         8'h08:   mem_word = 32'h00200113;
         8'h0C:   mem_word = 32'h00308193;
         8'h10:   mem_word = 32'h00408213;
         8'h48:   mem_word = 32'h02b02823;
         8'h4C:   mem_word = 32'h03002603;
         default: mem_word = {a, 8'hC3, ~a, 8'h5A};
      endcase
   endfunction

   assign imem_instr = mem_word(imem_addr);

   // Reference model: entries are {pc, instr}; m_pc is the next fetch address.
   logic [39:0] exp_q[$];
   logic [7:0]  m_pc = 8'h00;

   task automatic model_edge(input logic r, input logic fe, input logic rdy,
                             input logic rdv, input logic [7:0] rpc);
      logic        do_pop;
      logic        do_push;
      logic [39:0] tmp;
      if (!r) begin
         exp_q.delete();
         m_pc = 8'h00;
      end else if (rdv) begin
         exp_q.delete();
         m_pc = {rpc[7:2], 2'b00};
      end else begin
         do_pop  = rdy && (exp_q.size() > 0);
         do_push = fe && ((exp_q.size() < 4) || do_pop);
         tmp = {m_pc, mem_word(m_pc)};
         if (do_pop) void'(exp_q.pop_front());
         if (do_push) begin
            exp_q.push_back(tmp);
            m_pc = m_pc + 8'd4;
         end
      end
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic chk_model();
      logic [39:0] head;
      head = (exp_q.size() > 0) ? exp_q[0] : 40'h0;
      chk("m_valid", 32'(if_valid), 32'(exp_q.size() > 0));
      chk("m_count", 32'(fifo_count), 32'(exp_q.size()));
      chk("m_pc", 32'(if_pc), 32'(head[39:32]));
      chk("m_instr", if_instr, head[31:0]);
      chk("m_addr", 32'(imem_addr), 32'(m_pc));
   endtask

   // One clock: drive inputs at the falling edge, update model at the rising edge, sample at next fall.
   task automatic cycle(input logic r, input logic fe, input logic rdy,
                        input logic rdv, input logic [7:0] rpc);
      rst_n = r; fetch_en = fe; if_ready = rdy; redirect_valid = rdv; redirect_pc = rpc;
      @(posedge clk);
      model_edge(r, fe, rdy, rdv, rpc);
      @(negedge clk);
      chk_model();
   endtask

   typedef struct {
      logic        r, fe, rdy, rdv;
      logic [7:0]  rpc;
      logic        ev;
      logic [7:0]  epc;
      logic [31:0] ei;
      logic [2:0]  ec;
      logic [7:0]  ea;
   } vec_t;

   vec_t vq[$];

   task automatic add_vec(input logic r, input logic fe, input logic rdy, input logic rdv,
                          input logic [7:0] rpc, input logic ev, input logic [7:0] epc,
                          input logic [31:0] ei, input logic [2:0] ec, input logic [7:0] ea);
      vec_t v;
      v.r = r; v.fe = fe; v.rdy = rdy; v.rdv = rdv; v.rpc = rpc;
      v.ev = ev; v.epc = epc; v.ei = ei; v.ec = ec; v.ea = ea;
      vq.push_back(v);
   endtask

   initial begin
      // Streaming after reset
      add_vec(0,0,0,0,8'h00, 0,8'h00,32'h0,        3'd0,8'h00);
      add_vec(1,1,1,0,8'h00, 1,8'h00,32'h00007033, 3'd1,8'h04);
      add_vec(1,1,1,0,8'h00, 1,8'h04,32'h00100093, 3'd1,8'h08);
      add_vec(1,1,1,0,8'h00, 1,8'h08,32'h00200113, 3'd1,8'h0C);
      // Fill with decode stalled, then full-and-pop streaming
      add_vec(0,0,0,0,8'h00, 0,8'h00,32'h0,        3'd0,8'h00);
      add_vec(1,1,0,0,8'h00, 1,8'h00,32'h00007033, 3'd1,8'h04);
      add_vec(1,1,0,0,8'h00, 1,8'h00,32'h00007033, 3'd2,8'h08);
      add_vec(1,1,0,0,8'h00, 1,8'h00,32'h00007033, 3'd3,8'h0C);
      add_vec(1,1,0,0,8'h00, 1,8'h00,32'h00007033, 3'd4,8'h10);
      add_vec(1,1,0,0,8'h00, 1,8'h00,32'h00007033, 3'd4,8'h10);
      add_vec(1,1,0,0,8'h00, 1,8'h00,32'h00007033, 3'd4,8'h10);
      add_vec(1,1,1,0,8'h00, 1,8'h04,32'h00100093, 3'd4,8'h14);
      add_vec(1,1,1,0,8'h00, 1,8'h08,32'h00200113, 3'd4,8'h18);
      add_vec(1,1,1,0,8'h00, 1,8'h0C,32'h00308193, 3'd4,8'h1C);
      add_vec(1,1,1,0,8'h00, 1,8'h10,32'h00408213, 3'd4,8'h20);
      // Misaligned redirect during streaming
      add_vec(1,1,1,1,8'h4B, 0,8'h00,32'h0,        3'd0,8'h48);
      add_vec(1,1,1,0,8'h00, 1,8'h48,32'h02b02823, 3'd1,8'h4C);
      add_vec(1,1,1,0,8'h00, 1,8'h4C,32'h03002603, 3'd1,8'h50);
      // Redirect to the top word and wrap
      add_vec(1,1,1,1,8'hFC, 0,8'h00,32'h0,        3'd0,8'hFC);
      add_vec(1,1,0,0,8'h00, 1,8'hFC,mem_word(8'hFC),3'd1,8'h00);
      add_vec(1,1,1,0,8'h00, 1,8'h00,32'h00007033, 3'd1,8'h04);
      // Mid-operation reset with three entries buffered
      add_vec(0,0,0,0,8'h00, 0,8'h00,32'h0,        3'd0,8'h00);
      add_vec(1,1,0,0,8'h00, 1,8'h00,32'h00007033, 3'd1,8'h04);
      add_vec(1,1,0,0,8'h00, 1,8'h00,32'h00007033, 3'd2,8'h08);
      add_vec(1,1,0,0,8'h00, 1,8'h00,32'h00007033, 3'd3,8'h0C);
      add_vec(0,1,1,0,8'h00, 0,8'h00,32'h0,        3'd0,8'h00);
      add_vec(1,1,0,0,8'h00, 1,8'h00,32'h00007033, 3'd1,8'h04);

      @(negedge clk);
      for (int i = 0; i < vq.size(); i++) begin
         cycle(vq[i].r, vq[i].fe, vq[i].rdy, vq[i].rdv, vq[i].rpc);
         chk($sformatf("v%0d_valid", i), 32'(if_valid),   32'(vq[i].ev));
         chk($sformatf("v%0d_pc", i),    32'(if_pc),      32'(vq[i].epc));
         chk($sformatf("v%0d_instr", i), if_instr,        vq[i].ei);
         chk($sformatf("v%0d_count", i), 32'(fifo_count), 32'(vq[i].ec));
         chk($sformatf("v%0d_addr", i),  32'(imem_addr),  32'(vq[i].ea));
      end

      // Redirect while fetch is disabled: flush, hold, then resume at the target
      cycle(1,1,0,0,8'h00);
      cycle(1,0,0,1,8'h4E);
      chk("rd_idle_addr", 32'(imem_addr), 32'h4C);
      cycle(1,0,1,0,8'h00);
      chk("rd_idle_hold", 32'(imem_addr), 32'h4C);
      cycle(1,1,0,0,8'h00);
      chk("rd_idle_resume", if_instr, 32'h03002603);

      // Redirect in the same cycle as a pop: the head is consumed, nothing new enqueued
      cycle(1,1,0,0,8'h00);
      cycle(1,1,1,1,8'h08);
      chk("rd_pop_count", 32'(fifo_count), 32'd0);
      cycle(1,1,1,0,8'h00);
      chk("rd_pop_head", 32'(if_pc), 32'h08);

      // Random traffic against the model
      for (int i = 0; i < 600; i++) begin
         cycle(($urandom_range(0, 59) != 0), ($urandom_range(0, 3) != 0),
               1'($urandom_range(0, 1)), ($urandom_range(0, 11) == 0),
               8'($urandom_range(0, 255)));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
